// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow monitored clock
// in clk_in cycles, with a sticky timeout when the monitored clock stops.
module clock_period_meter #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(4_000_000)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic             sig_level,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_lat, hi_lat_nxt;
  logic [WIDTH-1:0] period_nxt, high_time_nxt;
  logic             valid_nxt, timeout_nxt;

  // Two-flop synchronizer plus one extra stage for edge detection.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_level = s2;
  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;

  // State and measurement registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= WAIT_FIRST;
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_lat    <= hi_lat_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state and measurement update; a rise always takes priority over timeout.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_lat_nxt    = hi_lat;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    timeout_nxt   = timeout;

    unique case (state)
      WAIT_FIRST: begin
        if (rise) begin
          cnt_nxt   = WIDTH'(1);
          state_nxt = MEASURE;
        end else if (cnt == TIMEOUT) begin
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end

      MEASURE: begin
        if (rise) begin
          period_nxt    = cnt;
          high_time_nxt = hi_lat;
          valid_nxt     = 1'b1;
          timeout_nxt   = 1'b0;
          cnt_nxt       = WIDTH'(1);
        end else begin
          if (fall) begin
            hi_lat_nxt = cnt;
          end
          if (cnt == TIMEOUT) begin
            timeout_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = WAIT_FIRST;
          end else begin
            cnt_nxt = cnt + WIDTH'(1);
          end
        end
      end

      default: state_nxt = WAIT_FIRST;
    endcase
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed checks of the clock period meter.
module tb_clock_period_meter;

  localparam int unsigned W = 28;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b1;
  logic         sig_a  = 1'b0;
  logic         sig_b  = 1'b0;

  logic         lvl_a, val_a, to_a;
  logic [W-1:0] per_a, hi_a;
  logic         lvl_b, val_b, to_b;
  logic [W-1:0] per_b, hi_b;

  clock_period_meter #(.WIDTH(W), .TIMEOUT(28'd16)) dut_a (
    .clk_in    (clk_in),
    .reset     (reset),
    .sig_in    (sig_a),
    .sig_level (lvl_a),
    .period    (per_a),
    .high_time (hi_a),
    .valid     (val_a),
    .timeout   (to_a)
  );

  clock_period_meter #(.WIDTH(W), .TIMEOUT(28'd8)) dut_b (
    .clk_in    (clk_in),
    .reset     (reset),
    .sig_in    (sig_b),
    .sig_level (lvl_b),
    .period    (per_b),
    .high_time (hi_b),
    .valid     (val_b),
    .timeout   (to_b)
  );

  // Free-running board clock.
  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned  vseen_a = 0, vseen_b = 0;
  int unsigned  b2b_a = 0, b2b_b = 0;
  logic         last_val_a = 1'b0, last_val_b = 1'b0;
  logic [W-1:0] cap_per_a = '0, cap_hi_a = '0, cap_per_b = '0, cap_hi_b = '0;

  // Reference model of the expected measurement stream for dut_a.
  bit           armed = 1'b0;
  logic         exp_to = 1'b0;
  int unsigned  prev_hi = 0, prev_lo = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (val_a) begin
      if (last_val_a) b2b_a++;
      vseen_a++;
      cap_per_a = per_a;
      cap_hi_a  = hi_a;
    end
    if (val_b) begin
      if (last_val_b) b2b_b++;
      vseen_b++;
      cap_per_b = per_b;
      cap_hi_b  = hi_b;
    end
    last_val_a = val_a;
    last_val_b = val_b;
  endtask

  // One monitored cycle on dut_a; its valid reports the previous cycle.
  task automatic drive_cycle(input int unsigned hi, input int unsigned lo, input string tag);
    vseen_a = 0;
    sig_a = 1'b1;
    repeat (hi) tick();
    sig_a = 1'b0;
    repeat (lo) tick();
    if (armed) begin
      check({tag, " n_valid"}, vseen_a, 1);
      check({tag, " period"}, 32'(cap_per_a), prev_hi + prev_lo);
      check({tag, " high_time"}, 32'(cap_hi_a), prev_hi);
      exp_to = 1'b0;
    end else begin
      check({tag, " n_valid"}, vseen_a, 0);
    end
    check({tag, " timeout"}, 32'(to_a), 32'(exp_to));
    armed   = 1'b1;
    prev_hi = hi;
    prev_lo = lo;
  endtask

  initial begin
    int unsigned since;

    repeat (3) tick();
    check("rst period", 32'(per_a), 0);
    check("rst high_time", 32'(hi_a), 0);
    check("rst valid", 32'(val_a), 0);
    check("rst timeout", 32'(to_a), 0);
    check("rst sig_level", 32'(lvl_a), 0);
    reset = 1'b0;
    tick();

    // Divide-by-4 input: 2 high, 2 low.
    for (int i = 0; i < 6; i++) drive_cycle(2, 2, "div4");
    check("div4 level_low", 32'(lvl_a), 0);

    // Asymmetric input: 3 high, 7 low.
    for (int i = 0; i < 5; i++) drive_cycle(3, 7, "asym");

    // Hold low until timeout: 16 cycles after the last rise strobe.
    vseen_a = 0;
    since = prev_hi + prev_lo - 3;
    while (since < 15) begin
      tick();
      since++;
    end
    check("to before", 32'(to_a), 0);
    tick();
    check("to at limit", 32'(to_a), 1);
    repeat (20) tick();
    check("to sticky", 32'(to_a), 1);
    check("to no valid", vseen_a, 0);
    check("to period hold", 32'(per_a), 10);
    check("to high hold", 32'(hi_a), 3);
    armed  = 1'b0;
    exp_to = 1'b1;

    // Resume at period 6: first rise only re-arms.
    drive_cycle(3, 3, "resume");
    drive_cycle(3, 3, "resume");
    drive_cycle(3, 3, "resume");

    // Reset in the middle of a measurement.
    sig_a = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sig_a = 1'b0;
    check("midrst period", 32'(per_a), 0);
    check("midrst high_time", 32'(hi_a), 0);
    check("midrst valid", 32'(val_a), 0);
    check("midrst timeout", 32'(to_a), 0);
    check("midrst sig_level", 32'(lvl_a), 0);
    tick();
    armed  = 1'b0;
    exp_to = 1'b0;
    drive_cycle(2, 3, "postrst");
    drive_cycle(2, 3, "postrst");
    drive_cycle(2, 3, "postrst");

    check("a valid gap", b2b_a, 0);

    // dut_b: period exactly equal to TIMEOUT=8, rise wins.
    check("b idle timeout", 32'(to_b), 1);
    vseen_b = 0;
    for (int k = 0; k < 4; k++) begin
      sig_b = 1'b1;
      repeat (4) tick();
      sig_b = 1'b0;
      repeat (4) tick();
      check("b n_valid", vseen_b, k);
      if (k == 0) begin
        check("b arm timeout", 32'(to_b), 1);
      end else begin
        check("b period", 32'(cap_per_b), 8);
        check("b high_time", 32'(cap_hi_b), 4);
        check("b timeout", 32'(to_b), 0);
      end
    end
    check("b valid gap", b2b_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
